// File: rtl/ser_pkg.sv
// Shared definitions for the serial link blocks (serializer and deserializer).
// Bit-order constants, output-slot state encoding and the beat-to-bit mapping.
package ser_pkg;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Word bit position carried by beat number cnt of a frame.
    function automatic int ser_bit_index(input int cnt, input int width, input int msb_first);
        return (msb_first != ORDER_LSB_FIRST) ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/serial_to_parallel_demux_if.sv
// Bit-stream input and word-stream output of the serial-to-parallel demux.
// The master drives bits and consumes words; the slave is the demux itself.
interface serial_to_parallel_demux_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(WIDTH);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             frame_clr;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [IW-1:0]    bit_idx;

    modport master (
        output bit_in, bit_valid, frame_clr, word_ready,
        input  bit_ready, word_out, word_valid, bit_idx
    );

    modport slave (
        input  bit_in, bit_valid, frame_clr, word_ready,
        output bit_ready, word_out, word_valid, bit_idx
    );
endinterface

// File: rtl/ser_out_slot.sv
// One-entry valid/ready holding register for completed words.
// A load in the same cycle as a take replaces the word without a bubble.
module ser_out_slot
    import ser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_t state, state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SLOT_EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (!load && take) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == SLOT_FULL);
    end

    // NOTE: the data register is reset too, so word_out reads zero out of reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data <= '0;
        else if (load) data <= load_data;
    end

endmodule

// File: rtl/serial_to_parallel_demux.sv
// Assembles serial beats into WIDTH-bit words (LSB- or MSB-first) and hands
// them out through a one-word holding slot so the next frame keeps arriving.
module serial_to_parallel_demux
    import ser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = ORDER_LSB_FIRST
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_to_parallel_demux_if.slave   bus
);

    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    logic [IW-1:0]    cnt;
    logic [IW-1:0]    pos;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] full_word;
    logic             last_beat;
    logic             accept;
    logic             complete;
    logic             word_valid;

    assign last_beat = (cnt == LAST);

    // Only the completing beat waits on a held word; word_ready frees it in the same cycle.
    assign bus.bit_ready = !bus.frame_clr && (!last_beat || !word_valid || bus.word_ready);
    assign accept        = bus.bit_valid && bus.bit_ready;
    assign complete      = accept && last_beat;

    always_comb begin
        pos            = IW'(ser_bit_index(int'(cnt), WIDTH, MSB_FIRST));
        full_word      = asm_q;
        full_word[pos] = bus.bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (bus.frame_clr || complete) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            cnt        <= cnt + 1'b1;
            asm_q[pos] <= bus.bit_in;
        end
    end

    ser_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (full_word),
        .take      (bus.word_ready),
        .data      (bus.word_out),
        .valid     (word_valid)
    );

    assign bus.word_valid = word_valid;
    assign bus.bit_idx    = cnt;

endmodule

// File: tb/tb_serial_to_parallel_demux.sv
// Directed bench for serial_to_parallel_demux: LSB-first and MSB-first instances
// share one stimulus and are compared every cycle against a queue-based frame model.
module tb_serial_to_parallel_demux;
    import ser_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_to_parallel_demux_if #(.WIDTH(W)) if_lsb ();
    serial_to_parallel_demux_if #(.WIDTH(W)) if_msb ();

    serial_to_parallel_demux #(.WIDTH(W), .MSB_FIRST(ORDER_LSB_FIRST)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lsb.slave)
    );

    serial_to_parallel_demux #(.WIDTH(W), .MSB_FIRST(ORDER_MSB_FIRST)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_msb.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame model: bits of the open frame in arrival order, plus the held word.
    bit             q[$];
    logic [W-1:0]   m_lsb   = '0;
    logic [W-1:0]   m_msb   = '0;
    logic           m_valid = 1'b0;
    logic           m_done;

    function automatic logic m_ready();
        return !if_lsb.frame_clr && ((q.size() < W - 1) || !m_valid || if_lsb.word_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_lsb   = '0;
            m_msb   = '0;
            m_valid = 1'b0;
        end else begin
            m_done = 1'b0;
            if (if_lsb.frame_clr) begin
                q.delete();
            end else if (if_lsb.bit_valid && m_ready()) begin
                q.push_back(if_lsb.bit_in);
                if (q.size() == W) begin
                    for (int k = 0; k < W; k++) begin
                        m_lsb[k]         = q[k];
                        m_msb[W - 1 - k] = q[k];
                    end
                    q.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done)                  m_valid = 1'b1;
            else if (if_lsb.word_ready)  m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("lsb_ready", 32'(if_lsb.bit_ready),  32'(m_ready()));
        check("msb_ready", 32'(if_msb.bit_ready),  32'(m_ready()));
        check("lsb_valid", 32'(if_lsb.word_valid), 32'(m_valid));
        check("msb_valid", 32'(if_msb.word_valid), 32'(m_valid));
        check("lsb_idx",   32'(if_lsb.bit_idx),    32'(q.size()));
        check("msb_idx",   32'(if_msb.bit_idx),    32'(q.size()));
        if (m_valid) begin
            check("lsb_word", 32'(if_lsb.word_out), 32'(m_lsb));
            check("msb_word", 32'(if_msb.word_out), 32'(m_msb));
        end
    end

    logic rdy_l, rdy_m;

    // One clock: apply inputs, note bit_ready before the edge, return after the edge.
    task automatic cyc(input logic v, input logic b, input logic clr, input logic wr);
        if_lsb.bit_valid = v;   if_msb.bit_valid = v;
        if_lsb.bit_in = b;      if_msb.bit_in = b;
        if_lsb.frame_clr = clr; if_msb.frame_clr = clr;
        if_lsb.word_ready = wr; if_msb.word_ready = wr;
        #1;
        rdy_l = if_lsb.bit_ready;
        rdy_m = if_msb.bit_ready;
        @(negedge clk);
        #1;
    endtask

    // n beats; bits[k] is the k-th bit to arrive.
    task automatic feed(input int n, input logic [7:0] bits, input logic wr);
        for (int k = 0; k < n; k++) cyc(1'b1, bits[k], 1'b0, wr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(if_lsb.word_valid), 32'd0);
        check("rst_word",  32'(if_lsb.word_out),   32'd0);
        check("rst_idx",   32'(if_lsb.bit_idx),    32'd0);
        rst_n = 1'b1;

        // 1: beats 0,1,0,1 with word_ready held high.
        feed(3, 8'b0000_1010, 1'b1);
        check("t1_valid_early", 32'(if_lsb.word_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("t1_valid", 32'(if_lsb.word_valid), 32'd1);
        check("t1_word",  32'(if_lsb.word_out),   32'h0000_000a);
        check("t2_word",  32'(if_msb.word_out),   32'h0000_0005);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_drop", 32'(if_lsb.word_valid), 32'd0);

        // 2: same beats, watch bit_idx step 1,2,3,0.
        check("t2_idx0", 32'(if_msb.bit_idx), 32'd0);
        pat = 4'b1010;
        for (int k = 0; k < W; k++) begin
            cyc(1'b1, pat[k], 1'b0, 1'b1);
            check("t2_idx", 32'(if_msb.bit_idx), 32'((k + 1) % W));
        end
        check("t2_word_again", 32'(if_msb.word_out), 32'h0000_0005);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 3: held word stalls only the completing beat.
        feed(4, 8'b0000_0011, 1'b0);
        check("t3_word_a", 32'(if_lsb.word_out), 32'h0000_0003);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            check("t3_partial_rdy", 32'(rdy_l), 32'd1);
        end
        check("t3_idx3", 32'(if_lsb.bit_idx), 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_stall",      32'(rdy_l),            32'd0);
        check("t3_word_held",  32'(if_lsb.word_out),  32'h0000_0003);
        check("t3_idx_held",   32'(if_lsb.bit_idx),   32'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_release_rdy", 32'(rdy_l),             32'd1);
        check("t3_word_b",      32'(if_lsb.word_out),   32'h0000_0005);
        check("t3_valid_b",     32'(if_lsb.word_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 4: completion and take in the same cycle, no bubble.
        feed(4, 8'b0000_1111, 1'b0);
        feed(3, 8'b0000_0110, 1'b0);
        check("t4_word_a",  32'(if_lsb.word_out),   32'h0000_000f);
        check("t4_valid_a", 32'(if_lsb.word_valid), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_valid_b", 32'(if_lsb.word_valid), 32'd1);
        check("t4_word_b",  32'(if_lsb.word_out),   32'h0000_0006);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 5: frame_clr drops the partial frame and the simultaneous bit.
        feed(2, 8'b0000_0011, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clr_rdy", 32'(rdy_m),          32'd0);
        check("t5_idx",     32'(if_lsb.bit_idx), 32'd0);
        feed(4, 8'b0000_0100, 1'b1);
        check("t5_word",  32'(if_lsb.word_out), 32'h0000_0004);
        check("t5_mword", 32'(if_msb.word_out), 32'h0000_0002);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 6: async reset with a held word and a partial frame.
        feed(4, 8'b0000_1001, 1'b0);
        feed(3, 8'b0000_0111, 1'b0);
        check("t6_pre_valid", 32'(if_lsb.word_valid), 32'd1);
        check("t6_pre_idx",   32'(if_lsb.bit_idx),    32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(if_lsb.word_valid), 32'd0);
        check("t6_rst_word",  32'(if_lsb.word_out),   32'd0);
        check("t6_rst_mword", 32'(if_msb.word_out),   32'd0);
        check("t6_rst_idx",   32'(if_lsb.bit_idx),    32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        feed(4, 8'b0000_0001, 1'b1);
        check("t6_word",  32'(if_lsb.word_out),   32'h0000_0001);
        check("t6_mword", 32'(if_msb.word_out),   32'h0000_0008);
        check("t6_valid", 32'(if_lsb.word_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
